// File: rtl/tcc_pkg.sv
// Shared definitions for the TCC byte cipher: FSM state encoding, byte width,
// the forward transform and the per-borrow inverse candidate.
package tcc_pkg;

    localparam int TCC_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAND0 = 2'd1,
        CAND1 = 2'd2,
        DONE  = 2'd3
    } tcc_state_e;

    function automatic logic [TCC_BYTE_W-1:0] tcc_forward(
        input logic [TCC_BYTE_W-1:0] p,
        input logic [TCC_BYTE_W-1:0] k
    );
        logic [TCC_BYTE_W-1:0] i1;
        logic [TCC_BYTE_W-1:0] i2;
        logic [TCC_BYTE_W-1:0] i3;
        i1 = p ^ k;
        i2 = i1 + k;
        i3 = i2 ^ (i1 >> 4);
        return i3 ^ k;
    endfunction

    // The carry out of the low-nibble add is unknown when inverting, so the
    // caller tries both borrow values and keeps whichever re-encodes.
    function automatic logic [TCC_BYTE_W-1:0] tcc_candidate(
        input logic [TCC_BYTE_W-1:0] c,
        input logic [TCC_BYTE_W-1:0] k,
        input logic                  b
    );
        logic [TCC_BYTE_W-1:0] t;
        logic [TCC_BYTE_W-1:0] s;
        logic [3:0]            h;
        t = c ^ k;
        h = t[7:4] - k[7:4] - {3'b000, b};
        s = {t[7:4], t[3:0] ^ h};
        return (s - k) ^ k;
    endfunction

endpackage

// File: rtl/tcc_fwd_core.sv
// Combinational forward TCC transform, used to verify a decode candidate.
module tcc_fwd_core
    import tcc_pkg::*;
(
    input  logic [7:0] p,
    input  logic [7:0] k,
    output logic [7:0] c
);

    assign c = tcc_forward(p, k);

endmodule

// File: rtl/tcc_decode.sv
// Multi-cycle TCC byte decoder: tries both borrow candidates on one shared
// forward core. Optional error counter enabled by TCC_DEC_ERR_CNT_EN.
module tcc_decode
    import tcc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       ciphertext,
    input  logic [7:0]       key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       plaintext,
    output logic             ambiguous,
    output logic             error,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_CAND0 = CAND0;
    localparam logic [1:0] S_CAND1 = CAND1;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0] state;
    logic [7:0] c_q;
    logic [7:0] k_q;
    logic [7:0] p0_q;
    logic [7:0] p1_q;
    logic       hit0_q;
    logic       hit1_q;
    logic [7:0] cand_p;
    logic [7:0] fwd_c;
    logic       hit;
    logic       in_done;

    // The borrow under test follows the state, so one core serves both passes.
    assign cand_p = tcc_candidate(c_q, k_q, state == S_CAND1);
    assign hit    = (fwd_c == c_q);

    tcc_fwd_core u_fwd (
        .p (cand_p),
        .k (k_q),
        .c (fwd_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            c_q    <= '0;
            k_q    <= '0;
            p0_q   <= '0;
            p1_q   <= '0;
            hit0_q <= 1'b0;
            hit1_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        c_q   <= ciphertext;
                        k_q   <= key;
                        state <= S_CAND0;
                    end
                end
                S_CAND0: begin
                    p0_q   <= cand_p;
                    hit0_q <= hit;
                    state  <= S_CAND1;
                end
                S_CAND1: begin
                    p1_q   <= cand_p;
                    hit1_q <= hit;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_done   = (state == S_DONE);
    assign in_ready  = (state == S_IDLE) & ~rst;
    assign out_valid = in_done;

    // Results are held in registers, so gating with DONE keeps them stable
    // under back-pressure and zero everywhere else.
    assign plaintext = !in_done ? 8'h00 : hit0_q ? p0_q : hit1_q ? p1_q : 8'h00;
    assign ambiguous = in_done & hit0_q & hit1_q;
    assign error     = in_done & ~hit0_q & ~hit1_q;

`ifdef TCC_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (in_done && out_ready && error && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_tcc_decode.sv
// Directed self-checking bench for tcc_decode; expected results come from a
// brute-force search over all plaintexts using the forward transform.
module tb_tcc_decode;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       ciphertext = 8'h00;
    logic [7:0]       key = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       plaintext;
    logic             ambiguous;
    logic             error;
    logic [CNT_W-1:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    tcc_decode #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .ambiguous  (ambiguous),
        .error      (error),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fwd(input logic [7:0] p, input logic [7:0] k);
        logic [7:0] i1;
        logic [7:0] i2;
        logic [7:0] i3;
        i1 = p ^ k;
        i2 = i1 + k;
        i3 = i2 ^ (i1 >> 4);
        return i3 ^ k;
    endfunction

    // The b=0 preimage is the one whose low-nibble add produces no carry.
    function automatic void model(input logic [7:0] c, input logic [7:0] k,
                                  output logic [7:0] ep, output logic eamb, output logic eerr);
        int n;
        logic [7:0] pany;
        logic [7:0] pnc;
        logic [7:0] pv;
        n = 0;
        pany = 8'h00;
        pnc = 8'h00;
        for (int p = 0; p < 256; p++) begin
            pv = 8'(p);
            if (fwd(pv, k) == c) begin
                n++;
                pany = pv;
                if ((5'({1'b0, pv[3:0] ^ k[3:0]}) + 5'({1'b0, k[3:0]})) < 5'd16) pnc = pv;
            end
        end
        eerr = (n == 0);
        eamb = (n == 2);
        ep   = (n == 0) ? 8'h00 : (n == 1) ? pany : pnc;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_decode(input logic [7:0] c_in, input logic [7:0] k_in,
                             output logic [7:0] p_o, output logic amb_o,
                             output logic err_o, output int lat_o);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick;
            w++;
        end
        ciphertext = c_in;
        key        = k_in;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        tick;
        in_valid = 1'b0;
        lat_o = -1;
        for (int i = 1; i <= 10; i++) begin
            if (out_valid) begin
                lat_o = i;
                break;
            end
            tick;
        end
        p_o   = plaintext;
        amb_o = ambiguous;
        err_o = error;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if ({plaintext, ambiguous, error} !== 10'h000) begin n_fail++; $display("[TB] FAIL rst_outputs: got %h/%b/%b expected 00/0/0", plaintext, ambiguous, error); end
        n_cmp++; if (err_count !== '0) begin n_fail++; $display("[TB] FAIL rst_err_count: got %0d expected 0", err_count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic;
        logic [7:0] p;
        logic a, e;
        int lat;
        do_decode(8'h73, 8'h13, p, a, e, lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL latency_73: got %0d expected 3", lat); end
        n_cmp++; if ({p, a, e} !== {8'h41, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL decode_73: got %h/%b/%b expected 41/0/0", p, a, e); end
        do_decode(8'hAF, 8'h00, p, a, e, lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL latency_AF: got %0d expected 3", lat); end
        n_cmp++; if ({p, a, e} !== {8'hA5, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL decode_AF: got %h/%b/%b expected A5/0/0", p, a, e); end
    endtask

    task automatic test_sweep;
        logic [7:0] p, ep, cv;
        logic a, e, ea, ee;
        int lat, n_err, n_amb, exp_cnt, max_cnt;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_err = 0;
        n_amb = 0;
        for (int c = 0; c < 256; c++) begin
            cv = 8'(c);
            model(cv, 8'h13, ep, ea, ee);
            do_decode(cv, 8'h13, p, a, e, lat);
            if (e) n_err++;
            if (a) n_amb++;
            n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL sweep_latency c=%h: got %0d expected 3", cv, lat); end
            n_cmp++; if ({p, a, e} !== {ep, ea, ee}) begin n_fail++; $display("[TB] FAIL sweep c=%h: got %h/%b/%b expected %h/%b/%b", cv, p, a, e, ep, ea, ee); end
            if (!ee) begin
                n_cmp++; if (fwd(p, 8'h13) !== cv) begin n_fail++; $display("[TB] FAIL sweep_reencode c=%h: got %h expected %h", cv, fwd(p, 8'h13), cv); end
            end
        end
        n_cmp++; if (n_err !== n_amb) begin n_fail++; $display("[TB] FAIL sweep_err_vs_amb: got %0d errors expected %0d (ambiguous)", n_err, n_amb); end
        max_cnt = (1 << CNT_W) - 1;
`ifdef TCC_DEC_ERR_CNT_EN
        exp_cnt = (n_err > max_cnt) ? max_cnt : n_err;
`else
        exp_cnt = 0;
`endif
        n_cmp++; if (int'(err_count) !== exp_cnt) begin n_fail++; $display("[TB] FAIL sweep_err_count: got %0d expected %0d", err_count, exp_cnt); end
    endtask

    task automatic test_backpressure;
        logic [7:0] p;
        logic a, e;
        int lat, w;
        ciphertext = 8'h73;
        key        = 8'h13;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        tick;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 10) begin
            tick;
            w++;
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_reach_done: got %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            in_valid   = (i % 2 == 0);
            ciphertext = 8'hC0 + 8'(i);
            key        = 8'h55;
            tick;
            n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("[TB] FAIL bp_hold_%0d valid/ready: got %b%b expected 10", i, out_valid, in_ready); end
            n_cmp++; if ({plaintext, ambiguous, error} !== {8'h41, 2'b00}) begin n_fail++; $display("[TB] FAIL bp_stable_%0d: got %h/%b/%b expected 41/0/0", i, plaintext, ambiguous, error); end
        end
        in_valid   = 1'b1;
        ciphertext = 8'hAF;
        key        = 8'h00;
        out_ready  = 1'b1;
        tick;
        out_ready = 1'b0;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL bp_release_no_accept: got valid/ready %b%b expected 01", out_valid, in_ready); end
        in_valid = 1'b0;
        do_decode(8'hAF, 8'h00, p, a, e, lat);
        n_cmp++; if ({p, a, e} !== {8'hA5, 2'b00} || lat !== 3) begin n_fail++; $display("[TB] FAIL bp_followup: got %h/%b/%b lat %0d expected A5/0/0 lat 3", p, a, e, lat); end
    endtask

    task automatic test_abort;
        logic [7:0] p;
        logic a, e;
        logic seen;
        int lat;
        ciphertext = 8'h73;
        key        = 8'h13;
        in_valid   = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        n_cmp++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_in_reset: got valid/ready %b%b expected 00", out_valid, in_ready); end
        n_cmp++; if ({plaintext, error} !== 9'h000) begin n_fail++; $display("[TB] FAIL abort_outputs: got %h/%b expected 00/0", plaintext, error); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_ready_after: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_output: got out_valid %b expected 0", seen); end
        do_decode(8'hAF, 8'h00, p, a, e, lat);
        n_cmp++; if ({p, a, e} !== {8'hA5, 2'b00} || lat !== 3) begin n_fail++; $display("[TB] FAIL abort_followup: got %h/%b/%b lat %0d expected A5/0/0 lat 3", p, a, e, lat); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vec [4];
        logic [7:0] got [$];
        logic [7:0] ep;
        logic ea, ee, acc;
        int idx, last_acc;
        vec[0] = 8'h73; vec[1] = 8'h10; vec[2] = 8'hAF; vec[3] = 8'h5C;
        idx = 0;
        last_acc = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid   = (idx < 4);
            ciphertext = (idx < 4) ? vec[idx] : 8'h00;
            key        = 8'h13;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(plaintext);
            tick;
            if (acc) begin
                if (last_acc >= 0) begin
                    n_cmp++; if (cyc - last_acc !== 4) begin n_fail++; $display("[TB] FAIL b2b_spacing_%0d: got %0d expected 4", idx, cyc - last_acc); end
                end
                last_acc = cyc;
                idx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (got.size() !== 4) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            model(vec[i], 8'h13, ep, ea, ee);
            n_cmp++; if (got[i] !== ep) begin n_fail++; $display("[TB] FAIL b2b_result_%0d: got %h expected %h", i, got[i], ep); end
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_basic;
        test_sweep;
        test_backpressure;
        test_abort;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/tcc_decode.md
TCC_DECODE -- requirements
Module: tcc_decode

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, the width of the error counter.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ciphertext/key offered
- in_ready  out  1  block can accept
- ciphertext  in  8  encoded byte
- key  in  8  cipher key
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- plaintext  out  8  decoded byte
- ambiguous  out  1  two preimages exist; the lower candidate (b=0) is reported
- error  out  1  no preimage exists
- err_count  out  CNT_W  saturating count of error results

Function
REQ-010 The forward transform SHALL be defined as: i1=p^k; i2=i1+k mod 256; i3=i2^(i1>>4); c=i3^k.
REQ-011 Candidate plaintext p_b for borrow b in {0,1} SHALL be computed as follows.
- t=c^k
- h=(t[7:4]-k[7:4]-b) mod 16
- s={t[7:4], t[3:0]^h}
- p_b=((s-k) mod 256)^k
REQ-012 A candidate SHALL be a hit when forward(p_b,k)==c.
REQ-013 The FSM states SHALL be IDLE, CAND0, CAND1 and DONE.
REQ-014 The FSM transitions SHALL be:
- IDLE->CAND0 on in_valid&in_ready; c and k are latched in this cycle.
- CAND0->CAND1 unconditionally; p0 and hit0 are registered.
- CAND1->DONE unconditionally; p1 and hit1 are registered.
- DONE->IDLE on out_ready.
REQ-015 in_ready SHALL equal (state==IDLE)&!rst.
REQ-016 out_valid SHALL be 1 only in DONE.
REQ-017 The output rule in DONE SHALL be:
- plaintext = hit0 ? p0 : hit1 ? p1 : 0x00
- ambiguous = hit0&hit1
- error = !hit0&!hit1
REQ-018 Latency: a handshake in cycle N SHALL give out_valid=1 in cycle N+3.
REQ-019 Throughput: with out_ready held at 1, the block SHALL accept one input every 4 cycles.
REQ-020 Back-pressure: while out_valid=1 and out_ready=0, plaintext, ambiguous and error SHALL remain stable.
REQ-021 Inputs presented outside IDLE SHALL be ignored, and the latched c and k SHALL not change.
REQ-022 If out_ready=1 in DONE while in_valid=1, the block SHALL return to IDLE and SHALL NOT accept that input until the following cycle.
REQ-023 err_count SHALL increment by 1 on each DONE->IDLE transfer with error=1, and SHALL saturate at all-ones.

Reset
REQ-030 rst SHALL force, on the next clk edge:
- state to IDLE
- plaintext, ambiguous, error, out_valid to 0
- err_count to 0
- latched c, k and candidate registers to 0
REQ-031 A reset asserted in any state, including mid-decode, SHALL discard the operation in flight and SHALL NOT produce any output handshake for it.
REQ-032 in_ready SHALL be 0 while rst=1.

Configuration
REQ-040 The macro TCC_DEC_ERR_CNT_EN SHALL control the error counter.
REQ-041 With TCC_DEC_ERR_CNT_EN defined, err_count SHALL behave per REQ-023.
REQ-042 Without TCC_DEC_ERR_CNT_EN, the err_count port SHALL be present and tied to 0, no counter register SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-050 A shared package tcc_pkg SHALL hold:
- the FSM state enum
- TCC_BYTE_W=8
- the forward-transform function used by both the encoder and this block
REQ-051 The forward check SHALL be one combinational sub-module, tcc_fwd_core (inputs p and k, output c), instantiated once and time-shared between CAND0 and CAND1.

Verification
REQ-060 The bench SHALL cover these scenarios:
- c=0x73, k=0x13 -> plaintext=0x41, ambiguous=0, error=0, out_valid exactly 3 cycles after the accept.
- c=0xAF, k=0x00 -> plaintext=0xA5, ambiguous=0, error=0.
- Sweep all 256 c with k=0x13 -> every non-error result re-encodes to c; number of error results equals number of ambiguous results; err_count equals the error total, or saturates if CNT_W is small.
- out_ready=0 held 5 cycles in DONE -> outputs stable and in_ready=0 throughout; in_valid pulses ignored; one transfer on release.
- rst=1 asserted in CAND1 -> next cycle state IDLE, out_valid=0, in_ready=1 after release, no output for the aborted item.
- Back-to-back inputs with out_ready=1 -> accepts spaced exactly 4 cycles apart; results in order.
